// File: rtl/unos_pkg.sv
// rtl/unos_pkg.sv - shared state encoding and default widths for the thermometer generator
package unos_pkg;

   localparam int N_DEF  = 8;
   localparam int CW_DEF = $clog2(N_DEF + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/reg_desp.sv
// rtl/reg_desp.sv - N-bit right-shift register with serial MSB input and load-zero
module reg_desp #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {din, q[N-1:1]};
      end
   end

endmodule

// File: rtl/genera_unos.sv
// rtl/genera_unos.sv - serially builds an N-bit thermometer code with cuenta low-order ones
module genera_unos
   import unos_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] cuenta,
   input  logic          start,
   output logic [N-1:0]  valor,
   output logic          fin
);

   state_t        state, state_nxt;
   logic [CW-1:0] k, i;
   logic [CW-1:0] k_ini;
   logic          load, shift;

   // Counts above N would overrun the word; clamp so the result is all ones.
   always_comb begin
      k_ini = cuenta;
      if (int'(cuenta) > N) begin
         k_ini = CW'(N);
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            if (i == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         k     <= '0;
         i     <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            k <= k_ini;
            i <= CW'(N);
         end else if (shift) begin
            i <= i - CW'(1);
            if (k != '0) begin
               k <= k - CW'(1);
            end
         end
      end
   end

   reg_desp #(.N(N)) u_reg_desp (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load),
      .en    (shift),
      .din   (k != '0),
      .q     (valor)
   );

   assign fin = (state == DONE);

endmodule

// File: tb/tb_genera_unos.sv
// tb/tb_genera_unos.sv - directed self-checking bench for genera_unos
module tb_genera_unos;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] cuenta;
   logic       start;
   logic [7:0] valor;
   logic       fin;

   int checks   = 0;
   int failures = 0;

   genera_unos #(.N(8), .CW(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cuenta (cuenta),
      .start  (start),
      .valor  (valor),
      .fin    (fin)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One conversion from idle/done with a single-cycle start; fin must stay low E1..E7.
   task automatic run_conv(input logic [3:0] c, input logic [7:0] exp, input string tag);
      cuenta = c;
      start  = 1'b1;
      step();
      start  = 1'b0;
      check({tag, "_fin_e0"}, {31'd0, fin}, 32'd0);
      for (int n = 1; n < 8; n++) begin
         step();
         check({tag, "_fin_busy"}, {31'd0, fin}, 32'd0);
      end
      step();
      check({tag, "_fin"}, {31'd0, fin}, 32'd1);
      check({tag, "_valor"}, {24'd0, valor}, {24'd0, exp});
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b1;
      cuenta = 4'd7;
      step();
      step();
      check("rst_valor", {24'd0, valor}, 32'h00);
      check("rst_fin", {31'd0, fin}, 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      step();
      check("idle_fin", {31'd0, fin}, 32'd0);
      check("idle_valor", {24'd0, valor}, 32'h00);

      run_conv(4'd3, 8'h07, "c3");
      step();
      step();
      check("c3_hold_fin", {31'd0, fin}, 32'd1);
      check("c3_hold_valor", {24'd0, valor}, 32'h07);

      run_conv(4'd0, 8'h00, "c0");
      run_conv(4'd8, 8'hFF, "c8");
      run_conv(4'd13, 8'hFF, "c13");

      // Second request at E3 arrives while busy and must be dropped.
      cuenta = 4'd2;
      start  = 1'b1;
      step();
      start  = 1'b0;
      step();
      step();
      cuenta = 4'd6;
      start  = 1'b1;
      step();
      start  = 1'b0;
      for (int n = 4; n < 8; n++) begin
         step();
      end
      check("busy_fin_e7", {31'd0, fin}, 32'd0);
      step();
      check("busy_fin", {31'd0, fin}, 32'd1);
      check("busy_valor", {24'd0, valor}, 32'h03);

      cuenta = 4'd5;
      start  = 1'b1;
      step();
      start  = 1'b0;
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_valor", {24'd0, valor}, 32'h00);
      check("midrst_fin", {31'd0, fin}, 32'd0);
      run_conv(4'd1, 8'h01, "c1");

      // Start held high: one DONE cycle in every nine.
      cuenta = 4'd5;
      start  = 1'b1;
      step();
      for (int p = 0; p < 3; p++) begin
         for (int n = 1; n < 8; n++) begin
            step();
            check("stream_fin_low", {31'd0, fin}, 32'd0);
         end
         step();
         check("stream_fin", {31'd0, fin}, 32'd1);
         check("stream_valor", {24'd0, valor}, 32'h1F);
         check("loopback_count", $countones(valor), 32'd5);
         step();
         check("stream_restart", {31'd0, fin}, 32'd0);
      end
      start = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/genera_unos.md
# genera_unos

Inverse of the ones-counter datapath. Takes a count `cuenta` and builds, serially over N clock cycles, an N-bit word `valor` whose `cuenta` least-significant bits are 1 and the rest 0 (thermometer code). It uses the same `start`/`fin` handshake as the counter units. A `cuenta1` instance fed with `valor` must return the original (saturated) count, so the two blocks form a loop-back pair.

## Interface
Parameters:
- `N`, 8, output word width (N ≥ 2)
- `CW`, `$clog2(N+1)`, width of `cuenta` (default 4)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge
- `cuenta`  in  CW  number of ones requested; sampled only on an accepted start
- `start`  in  1  level-sampled request; accepted in IDLE or DONE
- `valor`  out  N  shift-register contents; valid only while `fin`=1
- `fin`  out  1  high in DONE; result valid

## Operation
- State machine with three states:
  - **IDLE** (reset state). `fin`=0.
  - **SHIFT**. `fin`=0. `start` is ignored.
  - **DONE**. `fin`=1. `valor` is held.
- Internal registers:
  - `k` (CW bits): ones still to insert.
  - `i` (CW bits): shifts remaining.
  - `sr` (N bits): the shift register. `valor` = `sr` at all times.
- **IDLE/DONE with `start`=1.** On the edge:
  - `k` ← min(`cuenta`, N). Counts above N saturate to N, giving all ones.
  - `i` ← N, `sr` ← 0, `fin` ← 0, go to SHIFT.
- **IDLE/DONE with `start`=0.** Hold everything.
- **SHIFT, each edge:**
  - `sr` ← {b, `sr`[N-1:1]} (right shift, insert at MSB), with b = (`k` ≠ 0).
  - If `k` ≠ 0, `k` ← `k`−1.
  - `i` ← `i`−1.
  - When `i`==1 before the edge, that edge performs the last shift and goes to DONE, with `fin` ← 1 on the same edge.
- **Result.** After N shifts the first-inserted bits sit at the LSBs, so `valor` = 2^k − 1, where k = min(`cuenta`, N).
- **Reset.** Takes priority over everything, including mid-SHIFT. On an edge with `rst_n`=0: state ← IDLE, `sr` ← 0, `k` ← 0, `i` ← 0, `fin` ← 0.
- **Reset values of outputs:** `valor`=0, `fin`=0.
- **Simultaneous events:**
  - `start` together with `rst_n`=0: reset wins and `start` is lost.
  - `start` on the edge that enters DONE is ignored, because the state is still SHIFT.
  - `start` held high: DONE lasts exactly one cycle and the next conversion begins.
- `cuenta` changes during SHIFT have no effect.

## Timing
- `start` is accepted at edge E0. Shifts happen at E1..EN. `fin` rises and `valor` is final after EN.
- Latency is N cycles from the accepted edge; 8 for the default.
- `fin` falls on the edge that accepts the next `start`.
- In back-to-back operation with `start` held at 1, the period is N+1 cycles.
- Intermediate `valor` values during SHIFT are visible but are not valid data.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package `unos_pkg` holds:
  - state encoding `IDLE`=2'b00, `SHIFT`=2'b01, `DONE`=2'b10
  - the default width constants
- Sub-module `reg_desp`: N-bit right-shift register with synchronous clear, load-zero and shift-enable, plus a serial MSB input.
  - Same role as the Q register in the counter datapath.
- The top level holds the FSM plus the `k` and `i` down-counters.

## Test plan
Defaults apply (N=8, CW=4).
1. **Reset:** `rst_n`=0 for 2 edges with `start`=1 → `valor`=8'h00, `fin`=0, still IDLE one edge after `rst_n`=1 if `start`=0.
2. **Basic conversion:** `cuenta`=3, 1-cycle `start` → `fin`=0 for edges E1..E7, `fin`=1 after E8, `valor`=8'b0000_0111. Held while `start`=0.
3. **Boundaries:**
   - `cuenta`=0 → 8'h00
   - `cuenta`=8 → 8'hFF
   - `cuenta`=13 → 8'hFF (saturation)
   - each with `fin` after exactly 8 cycles
4. **Busy ignore:** `cuenta`=2 start, then at E3 `start`=1 with `cuenta`=6 → result 8'h03 at E8. The second request is dropped.
5. **Reset mid-operation:** `cuenta`=5 start, `rst_n`=0 at E4 → after that edge `valor`=0, `fin`=0. A new start with `cuenta`=1 yields 8'h01 8 cycles later.
6. **Streaming plus loop-back:**
   - `start` held 1 with `cuenta`=5 → `fin` high one cycle in every 9, `valor`=8'h1F each time.
   - Feeding `valor` to the counter unit returns 5.
